// File: rtl/logic_preimage_finder_pkg.sv
// Shared types and the golden gate function for the preimage finder.
// The gate network is f(a,b,c) = (a & b) ^ (b | c).
package preimage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam int N_CAND = 8;

    function automatic logic gate_f(input logic a, input logic b, input logic c);
        return (a & b) ^ (b | c);
    endfunction

endpackage

// File: rtl/logic_preimage_finder_if.sv
// Request/stream bundle of the preimage finder; match_cnt exists only with PREIMAGE_CNT_EN.
// The master modport is the finder itself, slave is its driver/consumer.
interface logic_preimage_finder_if;
    logic       start;
    logic       target;
    logic       busy;
    logic       m_valid;
    logic       m_ready;
    logic [2:0] m_abc;
    logic       done;
`ifdef PREIMAGE_CNT_EN
    logic [3:0] match_cnt;

    modport master (input start, target, m_ready,
                    output busy, m_valid, m_abc, done, match_cnt);
    modport slave  (output start, target, m_ready,
                    input busy, m_valid, m_abc, done, match_cnt);
`else
    modport master (input start, target, m_ready,
                    output busy, m_valid, m_abc, done);
    modport slave  (output start, target, m_ready,
                    input busy, m_valid, m_abc, done);
`endif
endinterface

// File: rtl/logic_preimage_finder_gate_eval.sv
// Combinational evaluation of the gate network for one {a,b,c} candidate.
// Kept apart from the FSM so the evaluated function can be replaced.
module gate_eval
    import preimage_pkg::*;
(
    input  logic [2:0] idx,
    output logic       f
);
    assign f = gate_f(idx[2], idx[1], idx[0]);
endmodule

// File: rtl/logic_preimage_finder.sv
// Enumerates all {a,b,c} and streams those whose gate output equals the target.
// Optional match counter enabled by macro PREIMAGE_CNT_EN.
module logic_preimage_finder
    import preimage_pkg::*;
#(
    parameter bit DESC_ORDER = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    logic_preimage_finder_if.master  bus
);
    localparam logic [2:0] FIRST_IDX = DESC_ORDER ? 3'(N_CAND - 1) : 3'd0;
    localparam logic [2:0] LAST_IDX  = DESC_ORDER ? 3'd0 : 3'(N_CAND - 1);

    state_t     state_reg, state_next;
    logic [2:0] idx_reg, idx_next;
    logic       target_reg, target_next;
    logic       m_valid_reg, m_valid_next;
    logic [2:0] m_abc_reg, m_abc_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       f_idx;
    logic [2:0] idx_step;

    gate_eval u_gate_eval (
        .idx (idx_reg),
        .f   (f_idx)
    );

    assign idx_step = DESC_ORDER ? idx_reg - 3'd1 : idx_reg + 3'd1;

`ifdef PREIMAGE_CNT_EN
    logic [3:0] cnt_reg, cnt_next;
    logic [3:0] match_cnt_reg, match_cnt_next;
`endif

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        target_next  = target_reg;
        m_valid_next = m_valid_reg;
        m_abc_next   = m_abc_reg;
`ifdef PREIMAGE_CNT_EN
        cnt_next     = cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    target_next = bus.target;
                    idx_next    = FIRST_IDX;
                    state_next  = ST_SCAN;
`ifdef PREIMAGE_CNT_EN
                    cnt_next    = 4'd0;
`endif
                end
            end
            ST_SCAN: begin
                if (f_idx == target_reg) begin
                    m_abc_next   = idx_reg;
                    m_valid_next = 1'b1;
                    state_next   = ST_EMIT;
                end else if (idx_reg == LAST_IDX) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next = idx_step;
                end
            end
            ST_EMIT: begin
                if (m_valid_reg && bus.m_ready) begin
                    m_valid_next = 1'b0;
`ifdef PREIMAGE_CNT_EN
                    cnt_next     = cnt_reg + 4'd1;
`endif
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_step;
                        state_next = ST_SCAN;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Status outputs are registered, so they are derived from the next state.
        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
`ifdef PREIMAGE_CNT_EN
        match_cnt_next = (state_next == ST_DONE && state_reg != ST_DONE) ? cnt_next
                                                                          : match_cnt_reg;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= 3'd0;
            target_reg  <= 1'b0;
            m_valid_reg <= 1'b0;
            m_abc_reg   <= 3'd0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            target_reg  <= target_next;
            m_valid_reg <= m_valid_next;
            m_abc_reg   <= m_abc_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

`ifdef PREIMAGE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= 4'd0;
            match_cnt_reg <= 4'd0;
        end else begin
            cnt_reg       <= cnt_next;
            match_cnt_reg <= match_cnt_next;
        end
    end
    assign bus.match_cnt = match_cnt_reg;
`endif

    assign bus.busy    = busy_reg;
    assign bus.m_valid = m_valid_reg;
    assign bus.m_abc   = m_abc_reg;
    assign bus.done    = done_reg;

endmodule

// File: tb/tb_logic_preimage_finder.sv
// Bench for logic_preimage_finder: ascending and descending instances checked against
// a truth-table model, with random back-pressure, disturbance and mid-search reset.
module tb_logic_preimage_finder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_preimage_finder_if if_asc ();
    logic_preimage_finder_if if_desc ();

    logic_preimage_finder #(.DESC_ORDER(1'b0)) dut_asc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_asc)
    );
    logic_preimage_finder #(.DESC_ORDER(1'b1)) dut_desc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_desc)
    );

    logic       sel = 1'b0;
    logic       start_drv = 1'b0;
    logic       target_drv = 1'b0;
    logic       ready_drv = 1'b0;

    assign if_asc.start   = start_drv && !sel;
    assign if_desc.start  = start_drv && sel;
    assign if_asc.target  = target_drv;
    assign if_desc.target = target_drv;
    assign if_asc.m_ready = ready_drv;
    assign if_desc.m_ready = ready_drv;

    logic       obs_busy, obs_valid, obs_done;
    logic [2:0] obs_abc;
    assign obs_busy  = sel ? if_desc.busy    : if_asc.busy;
    assign obs_valid = sel ? if_desc.m_valid : if_asc.m_valid;
    assign obs_done  = sel ? if_desc.done    : if_asc.done;
    assign obs_abc   = sel ? if_desc.m_abc   : if_asc.m_abc;
`ifdef PREIMAGE_CNT_EN
    logic [3:0] obs_cnt;
    assign obs_cnt = sel ? if_desc.match_cnt : if_asc.match_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_cmp++;
        assert (observed === expected)
            $display("check %s: observed %0h expected %0h ok", tag, observed, expected);
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the f=1 set of the gate network, straight from its truth table.
    function automatic bit ref_f(input logic [2:0] cand);
        return (cand == 3'd1) || (cand == 3'd2) || (cand == 3'd3) || (cand == 3'd5);
    endfunction

    task automatic run_search(input bit desc, input bit tgt, input bit rnd,
                              input bit disturb, input bit timed);
        logic [2:0] exp_q[$];
        int         rises[$];
        int         done_cyc = -1;
        int         nrecv = 0;
        int         stall_left = 0;
        int         c = 0;
        bit         done_seen = 1'b0;
        bit         prev_stall = 1'b0;
        bit         prev_valid = 1'b0;
        logic [2:0] prev_abc = 3'd0;
        logic [2:0] cand;
        logic [2:0] exp_abc;

        for (int k = 0; k < 8; k++) begin
            cand = desc ? 3'(7 - k) : 3'(k);
            if (ref_f(cand) == tgt) exp_q.push_back(cand);
        end

        sel = desc;
        target_drv = tgt;
        start_drv = 1'b1;
        ready_drv = 1'b0;
        tick();
        start_drv = 1'b0;
        check("busy_after_start", 8'(obs_busy), 8'd1);

        while (!done_seen && c < 300) begin
            if (prev_stall) begin
                check("stall_valid", 8'(obs_valid), 8'd1);
                check("stall_abc", 8'(obs_abc), 8'(prev_abc));
            end
            if (obs_valid && !prev_valid) rises.push_back(c);
            if (obs_done) begin
                done_seen = 1'b1;
                done_cyc = c;
            end else begin
                if (disturb) begin
                    start_drv = (c % 3 == 0);
                    target_drv = 1'($urandom_range(0, 1));
                end
                if (!rnd) begin
                    ready_drv = 1'b1;
                end else if (stall_left > 0) begin
                    ready_drv = 1'b0;
                    stall_left--;
                end else if ($urandom_range(0, 3) == 0) begin
                    ready_drv = 1'b0;
                    stall_left = 5;
                end else begin
                    ready_drv = 1'($urandom_range(0, 1));
                end
                if (obs_valid && ready_drv) begin
                    nrecv++;
                    if (exp_q.size() > 0) begin
                        exp_abc = exp_q.pop_front();
                        check("stream_abc", 8'(obs_abc), 8'(exp_abc));
                    end
                end
                prev_stall = obs_valid && !ready_drv;
                prev_abc = obs_abc;
                prev_valid = obs_valid;
                tick();
                c++;
            end
        end
        start_drv = 1'b0;
        ready_drv = 1'b0;

        check("done_seen", 8'(done_seen), 8'd1);
        check("match_count", 8'(nrecv), 8'd4);
        check("missing_candidates", 8'(exp_q.size()), 8'd0);
        if (timed) begin
            check("done_cycle", 8'(done_cyc), 8'd12);
            check("rise_count", 8'(rises.size()), 8'd4);
            if (rises.size() == 4) begin
                check("rise0", 8'(rises[0]), 8'd2);
                check("rise1", 8'(rises[1]), 8'd4);
                check("rise2", 8'(rises[2]), 8'd6);
                check("rise3", 8'(rises[3]), 8'd9);
            end
        end
`ifdef PREIMAGE_CNT_EN
        check("match_cnt", 8'(obs_cnt), 8'd4);
`endif
        tick();
        check("done_single_pulse", 8'(obs_done), 8'd0);
        check("busy_after_done", 8'(obs_busy), 8'd0);
    endtask

    initial begin
        int guard;

        // Golden function against the truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            check("gate_f", 8'(preimage_pkg::gate_f(v[2], v[1], v[0])), 8'(ref_f(v)));
        end

        // Reset then idle.
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_busy", 8'(if_asc.busy | if_desc.busy), 8'd0);
            check("idle_valid", 8'(if_asc.m_valid | if_desc.m_valid), 8'd0);
            check("idle_abc", 8'(if_asc.m_abc | if_desc.m_abc), 8'd0);
            check("idle_done", 8'(if_asc.done | if_desc.done), 8'd0);
        end
`ifdef PREIMAGE_CNT_EN
        check("idle_cnt", 8'(if_asc.match_cnt | if_desc.match_cnt), 8'd0);
`endif

        // Ascending, target 1, ready held: exact timing.
        run_search(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        // Descending, target 0, ready held; back-to-back with the next start.
        run_search(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Random back-pressure with long stalls.
        run_search(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_search(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        // start/target disturbed while busy.
        run_search(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_search(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Reset while 010 is being offered.
        sel = 1'b0;
        target_drv = 1'b1;
        ready_drv = 1'b1;
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        guard = 0;
        while (!(obs_valid && obs_abc == 3'd2) && guard < 50) begin
            tick();
            guard++;
        end
        check("reach_010", 8'(obs_valid && obs_abc == 3'd2), 8'd1);
        ready_drv = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 8'(obs_busy), 8'd0);
        check("rst_valid", 8'(obs_valid), 8'd0);
        check("rst_abc", 8'(obs_abc), 8'd0);
        check("rst_done", 8'(obs_done), 8'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_done", 8'(obs_done), 8'd0);
            check("post_rst_busy", 8'(obs_busy), 8'd0);
        end
        run_search(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
